// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
package ps2_pkg;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_state_e;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_PARITY  = 2'd1,
        ERR_STOP    = 2'd2,
        ERR_TIMEOUT = 2'd3
    } ps2_err_e;

    localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PFX_BRK = 8'hF0;
    localparam int         PS2_KEY_W   = 10;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_key_t;

    function automatic logic odd_parity_ok(input logic [7:0] b, input logic p);
        return ^{b, p};
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Synchroniser + persistence filter for one raw PS/2 line, with a falling-edge strobe
// on the filtered level.
module ps2_line_filter
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_i,
    output logic level_o,
    output logic fall_o
);

    localparam int              FW   = $clog2(FILTER_LEN + 1);
    localparam logic [FW-1:0]   LAST = FW'(FILTER_LEN - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [FW-1:0]          cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   fall_q, fall_d;

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], raw_i};
        level_d = level_q;
        cnt_d   = '0;
        // Any sample matching the current level restarts the run.
        if (sync_q[SYNC_STAGES-1] != level_q) begin
            if (cnt_q == LAST) level_d = sync_q[SYNC_STAGES-1];
            else               cnt_d   = cnt_q + 1'b1;
        end
        fall_d = level_q & ~level_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '1;
            cnt_q   <= '0;
            level_q <= 1'b1;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            fall_q  <= fall_d;
        end
    end

    assign level_o = level_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/ps2_key_rx.sv
// PS/2 keyboard receiver: frame FSM, timeout, event FIFO with valid/ready.
// Define PS2_PREFIX_DECODE_EN to fold E0/F0 prefixes into the ext/brk event bits.
module ps2_key_rx
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int FIFO_DEPTH     = 8
) (
    input  logic                              i_clk,
    input  logic                              i_rst_n,
    input  logic                              i_ps2_clk,
    input  logic                              i_ps2_data,
    output logic                              o_valid,
    input  logic                              i_ready,
    output logic [PS2_KEY_W-1:0]              o_key,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   o_count,
    output logic                              o_busy,
    output logic                              o_err,
    output logic [1:0]                        o_err_code,
    output logic                              o_ovf
);

    localparam int            AW       = $clog2(FIFO_DEPTH);
    localparam int            CW       = $clog2(FIFO_DEPTH + 1);
    localparam int            TW       = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] DEPTH    = CW'(FIFO_DEPTH);

    logic ps2_fall, ps2_data, ps2_clk_lvl, data_fall_unused;

    ps2_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_clk_filt (
        .clk(i_clk), .rst_n(i_rst_n), .raw_i(i_ps2_clk), .level_o(ps2_clk_lvl), .fall_o(ps2_fall)
    );
    ps2_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_data_filt (
        .clk(i_clk), .rst_n(i_rst_n), .raw_i(i_ps2_data), .level_o(ps2_data), .fall_o(data_fall_unused)
    );

    ps2_state_e                      state_q, state_d;
    logic [2:0]                      idx_q, idx_d;
    logic [7:0]                      byte_q, byte_d;
    logic                            par_q, par_d;
    logic [TW-1:0]                   tmo_q, tmo_d;
    logic                            err_q, err_d;
    ps2_err_e                        err_code_q, err_code_d;
    logic                            ovf_q, ovf_d;
    logic                            good_byte, push, push_ok, pop, full, empty;
    ps2_key_t                        push_key;
    logic [FIFO_DEPTH-1:0][PS2_KEY_W-1:0] mem_q, mem_d;
    logic [CW-1:0]                   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        byte_d     = byte_q;
        par_d      = par_q;
        err_d      = 1'b0;
        err_code_d = err_code_q;
        good_byte  = 1'b0;
        if (ps2_fall || state_q == IDLE) tmo_d = '0;
        else if (tmo_q != TMO_LAST)      tmo_d = tmo_q + 1'b1;
        else                             tmo_d = tmo_q;

        if (ps2_fall) begin
            case (state_q)
                IDLE: if (!ps2_data) begin
                    state_d = DATA;
                    idx_d   = 3'd0;
                end
                DATA: begin
                    byte_d[idx_q] = ps2_data;
                    if (idx_q == 3'd7) state_d = PARITY;
                    else               idx_d   = idx_q + 1'b1;
                end
                PARITY: begin
                    par_d   = ps2_data;
                    state_d = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (!odd_parity_ok(byte_q, par_q)) begin
                        err_d      = 1'b1;
                        err_code_d = ERR_PARITY;
                    end else if (!ps2_data) begin
                        err_d      = 1'b1;
                        err_code_d = ERR_STOP;
                    end else begin
                        good_byte = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q != IDLE && tmo_q == TMO_LAST) begin
            // A fall in this cycle would have taken the branch above and cleared the timer.
            state_d    = IDLE;
            err_d      = 1'b1;
            err_code_d = ERR_TIMEOUT;
        end
    end

`ifdef PS2_PREFIX_DECODE_EN
    logic ext_q, ext_d, brk_q, brk_d;

    always_comb begin
        ext_d    = ext_q;
        brk_d    = brk_q;
        push     = 1'b0;
        push_key = '{ext: ext_q, brk: brk_q, code: byte_q};
        if (err_d) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end else if (good_byte) begin
            if (byte_q == PS2_PFX_EXT)      ext_d = 1'b1;
            else if (byte_q == PS2_PFX_BRK) brk_d = 1'b1;
            else begin
                push  = 1'b1;
                ext_d = 1'b0;
                brk_d = 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ext_q <= 1'b0;
            brk_q <= 1'b0;
        end else begin
            ext_q <= ext_d;
            brk_q <= brk_d;
        end
    end
`else
    assign push     = good_byte;
    assign push_key = '{ext: 1'b0, brk: 1'b0, code: byte_q};
`endif

    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = ((wr_ptr_q - rd_ptr_q) == DEPTH);
        pop      = !empty && i_ready;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        push_ok  = push && (!full || pop);
        ovf_d    = push && full && !pop;
        mem_d    = mem_q;
        if (push_ok) mem_d[wr_ptr_q[AW-1:0]] = push_key;
        wr_ptr_d = wr_ptr_q + CW'(push_ok);
        rd_ptr_d = rd_ptr_q + CW'(pop);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            byte_q     <= '0;
            par_q      <= 1'b0;
            tmo_q      <= '0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
            ovf_q      <= 1'b0;
            mem_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            byte_q     <= byte_d;
            par_q      <= par_d;
            tmo_q      <= tmo_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            ovf_q      <= ovf_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    assign o_valid    = !empty;
    assign o_key      = mem_q[rd_ptr_q[AW-1:0]];
    assign o_count    = wr_ptr_q - rd_ptr_q;
    assign o_busy     = (state_q != IDLE);
    assign o_err      = err_q;
    assign o_err_code = err_code_q;
    assign o_ovf      = ovf_q;

endmodule

// File: tb/tb_ps2_key_rx.sv
// Randomised bench for ps2_key_rx: drives PS/2 frames and compares against a byte-level event model.
module tb_ps2_key_rx;
    import ps2_pkg::*;

    localparam int SYNC  = 2;
    localparam int FILT  = 8;
    localparam int TMO   = 400;
    localparam int DEPTH = 8;
    localparam int HALF  = 20;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0, rst_n = 1'b0, ps2_clk = 1'b1, ps2_data = 1'b1, i_ready = 1'b0;
    logic          o_valid, o_busy, o_err, o_ovf;
    logic [9:0]    o_key;
    logic [CW-1:0] o_count;
    logic [1:0]    o_err_code;

    ps2_key_rx #(.SYNC_STAGES(SYNC), .FILTER_LEN(FILT), .TIMEOUT_CYCLES(TMO), .FIFO_DEPTH(DEPTH)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_ps2_clk(ps2_clk), .i_ps2_data(ps2_data),
        .o_valid(o_valid), .i_ready(i_ready), .o_key(o_key), .o_count(o_count),
        .o_busy(o_busy), .o_err(o_err), .o_err_code(o_err_code), .o_ovf(o_ovf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observed side: popped events, error/overflow pulses, o_valid rising edges.
    logic [9:0] got_q[$];
    int         err_cnt = 0, ovf_cnt = 0, rise_cyc = 0;
    logic       valid_prev = 1'b0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (o_valid && i_ready) got_q.push_back(o_key);
            if (o_err) err_cnt++;
            if (o_ovf) ovf_cnt++;
            if (o_valid && !valid_prev) rise_cyc = cyc;
        end
        valid_prev = o_valid;
    end

    // Reference model state.
    logic [9:0] exp_q[$];
    int         exp_err = 0, exp_code = 0, ev_idx = 0, stop_fall_cyc = 0, lat = 0;
    logic       m_ext = 1'b0, m_brk = 1'b0, rnd_on = 1'b0;
    int         n_chk = 0, n_err = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop);
        logic p;
        p = ~(^b) ^ bad_par;
        return {~bad_stop, p, b, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_data = bits[i];
            tick(HALF);
            ps2_clk = 1'b0;
            if (i == 10) stop_fall_cyc = cyc;
            tick(HALF);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        tick(2 * HALF);
    endtask

    task automatic model(input logic [7:0] b, input logic bad_par, input logic bad_stop);
        if (bad_par || bad_stop) begin
            exp_err++;
            exp_code = bad_par ? 1 : 2;
            m_ext = 1'b0;
            m_brk = 1'b0;
        end else begin
`ifdef PS2_PREFIX_DECODE_EN
            if (b == 8'hE0)      m_ext = 1'b1;
            else if (b == 8'hF0) m_brk = 1'b1;
            else begin
                exp_q.push_back({m_ext, m_brk, b});
                m_ext = 1'b0;
                m_brk = 1'b0;
            end
`else
            exp_q.push_back({2'b00, b});
`endif
        end
    endtask

    task automatic frame(input logic [7:0] b, input logic bad_par = 1'b0, input logic bad_stop = 1'b0);
        model(b, bad_par, bad_stop);
        send_bits(mk_frame(b, bad_par, bad_stop), 11);
    endtask

    task automatic check_err();
        chk("err_pulses", err_cnt, exp_err);
        chk("err_code", 32'(o_err_code), exp_code);
    endtask

    task automatic drain();
        i_ready = 1'b1;
        for (int i = 0; i < 4 * DEPTH && o_valid; i++) tick();
        i_ready = 1'b0;
        tick(2);
        chk("drained", 32'(o_valid), 0);
        chk("event_count", got_q.size(), exp_q.size());
        for (int i = ev_idx; i < exp_q.size() && i < got_q.size(); i++)
            chk("event", 32'(got_q[i]), 32'(exp_q[i]));
        ev_idx = exp_q.size();
    endtask

    initial begin
        #(100000 * 10);
        $display("FAIL watchdog: time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        int         ovf0;

        // Reset state
        tick(3);
        chk("rst_valid", 32'(o_valid), 0);
        chk("rst_key", 32'(o_key), 0);
        chk("rst_count", 32'(o_count), 0);
        chk("rst_busy", 32'(o_busy), 0);
        chk("rst_err", 32'(o_err), 0);
        chk("rst_code", 32'(o_err_code), 0);
        chk("rst_ovf", 32'(o_ovf), 0);
        rst_n = 1'b1;
        tick(5);

        // Single key, latency and head
        frame(8'h1C);
        lat = rise_cyc - stop_fall_cyc;
        chk("latency_window", int'(lat >= SYNC + FILT && lat <= SYNC + FILT + 3), 1);
        chk("head_key", 32'(o_key), 32'h01C);
        chk("head_count", 32'(o_count), 1);
        check_err();
        drain();

        // Prefix sequence
        frame(8'hE0);
        frame(8'hF0);
        frame(8'h75);
        drain();
        check_err();

        // Parity, stop and combined errors
        frame(8'h1C, 1'b1, 1'b0);
        check_err();
        chk("no_push_on_err", 32'(o_count), 0);
        frame(8'h32);
        drain();
        frame(8'h5A, 1'b0, 1'b1);
        check_err();
        frame(8'h5A, 1'b1, 1'b1);
        check_err();
        drain();

        // Timeout on a truncated frame; prefix flags must also drop
        frame(8'hE0);
        send_bits(mk_frame(8'h3C, 1'b0, 1'b0), 5);
        chk("busy_mid_frame", 32'(o_busy), 1);
        tick(TMO + 60);
        exp_err++;
        exp_code = 3;
        m_ext = 1'b0;
        m_brk = 1'b0;
        check_err();
        chk("busy_after_tmo", 32'(o_busy), 0);
        frame(8'h75);
        drain();

        // Short glitch on the PS/2 clock must not start a frame
        ps2_data = 1'b0;
        ps2_clk  = 1'b0;
        tick(FILT - 3);
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        tick(30);
        chk("glitch_busy", 32'(o_busy), 0);
        frame(8'h29);
        drain();
        check_err();

        // Random traffic with random back-pressure
        rnd_on = 1'b1;
        fork
            while (rnd_on) begin
                tick();
                i_ready = 1'($urandom_range(0, 1));
            end
        join_none
        for (int n = 0; n < 25; n++) begin
            case ($urandom_range(0, 7))
                0:       b = 8'hE0;
                1:       b = 8'hF0;
                default: b = 8'($urandom_range(0, 255));
            endcase
            frame(b, ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
            check_err();
        end
        rnd_on = 1'b0;
        tick(2);
        drain();

        // Overflow, then push+pop in the same cycle while full
        i_ready = 1'b0;
        ovf0 = ovf_cnt;
        for (int n = 0; n < DEPTH; n++) frame(8'($urandom_range(0, 8'hDF)));
        send_bits(mk_frame(8'h44, 1'b0, 1'b0), 11);
        chk("full_count", 32'(o_count), DEPTH);
        chk("ovf_once", ovf_cnt, ovf0 + 1);
        stop_fall_cyc = -1;
        model(8'h4B, 1'b0, 1'b0);
        fork
            send_bits(mk_frame(8'h4B, 1'b0, 1'b0), 11);
            begin
                for (int i = 0; i < 2000 && stop_fall_cyc < 0; i++) tick();
                while (cyc < stop_fall_cyc + lat - 1) tick();
                i_ready = 1'b1;
                tick();
                i_ready = 1'b0;
            end
        join
        chk("pushpop_no_ovf", ovf_cnt, ovf0 + 1);
        chk("pushpop_count", 32'(o_count), DEPTH);
        drain();
        check_err();

        // Reset in the middle of a frame
        frame(8'h1C);
        frame(8'hE0);
        send_bits(mk_frame(8'h3C, 1'b0, 1'b0), 4);
        chk("busy_before_rst", 32'(o_busy), 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(o_valid), 0);
        chk("midrst_count", 32'(o_count), 0);
        chk("midrst_busy", 32'(o_busy), 0);
        chk("midrst_key", 32'(o_key), 0);
        while (exp_q.size() > got_q.size()) void'(exp_q.pop_back());
        ev_idx   = exp_q.size();
        m_ext    = 1'b0;
        m_brk    = 1'b0;
        exp_code = 0;
        tick(3);
        rst_n = 1'b1;
        tick(TMO + 60);
        check_err();
        chk("busy_after_rst", 32'(o_busy), 0);
        frame(8'h75);
        drain();
        check_err();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
